// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of a synchronous
// instruction memory. The PC is driven combinationally onto mem_addr; the
// memory returns the addressed word on the following clk negedge. On the next
// posedge the word is captured into a one-entry output register and offered
// to decode with its own PC.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   mem_addr         word address to memory (copy of pc)
//   mem_rdata        word read from memory at mem_addr
//   instr, instr_pc  captured instruction and the address it came from
//   instr_valid      instr/instr_pc hold a live instruction
//   instr_ready      decode can take the instruction this cycle
//   redirect         one-cycle pulse: flush output, load redirect_target
//   redirect_target  new PC on redirect
//   resume           one-cycle pulse: leave HALT
//   halted           1 while in HALT
//   fault            1 once the PC has left the populated range (sticky)
//   state_dbg        current FSM state encoding, for observation only
//
// Handshake: an instruction transfers to decode on a clk posedge where
// instr_valid and instr_ready are both 1. While instr_valid is 1 and
// instr_ready is 0, instr and instr_pc stay stable until accepted or flushed
// by a redirect. instr_valid never drops without an accept, a redirect or
// a reset.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned        ADDR_W     = 10,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        MEM_DEPTH  = 128,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [5:0]         HLT_OPCODE = 6'b010010
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              resume,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // One extra bit so a depth equal to 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;

  logic                in_range;
  logic                accept;
  logic                slot_free;
  logic                is_hlt;

  assign in_range  = ({1'b0, pc_q} < DEPTH_LIM);
  assign accept    = valid_q & instr_ready;
  // The output slot can take a new word if it is empty or being drained now.
  assign slot_free = !valid_q | instr_ready;
  assign is_hlt    = (mem_rdata[DATA_W-1 -: 6] == HLT_OPCODE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      ST_START: begin
        // Memory has not yet read pc; no capture possible this cycle.
        state_d = ST_FETCH;
        if (redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end

      ST_FETCH: begin
        if (redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
        end else if (slot_free && in_range) begin
          instr_d    = mem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + 1'b1;
          // The hlt word itself is still delivered; only later fetches stop.
          if (is_hlt) begin
            state_d = ST_HALT;
          end
        end else begin
          if (!in_range) begin
            state_d = ST_FAULT;
          end
          // A pending word drains normally even while blocked or faulting.
          if (accept) begin
            valid_d = 1'b0;
          end
        end
      end

      ST_HALT: begin
        if (redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
          if (resume) begin
            state_d = ST_FETCH;
          end
        end else begin
          if (resume) begin
            state_d = ST_FETCH;
          end
          if (accept) begin
            valid_d = 1'b0;
          end
        end
      end

      ST_FAULT: begin
        // Terminal: redirect and resume are ignored until reset.
        if (accept) begin
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_FAULT;
      end
    endcase

    halted_d = (state_d == ST_HALT);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_START;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit with a behavioural instruction memory (read on clk
// negedge). Directed scenarios cover warm-up latency, stall, redirect, halt
// and resume, fault and asynchronous reset; a randomized phase then checks
// the delivered stream against an in-order PC model.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 32;
  localparam logic [5:0]  HLT_OP   = 6'b010010;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_target = '0;
  logic              resume = 1'b0;
  logic              halted;
  logic              fault;
  logic [1:0]        state_dbg;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .resume          (resume),
    .halted          (halted),
    .fault           (fault),
    .state_dbg       (state_dbg)
  );

  // instruction memory
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(negedge clk) mem_rdata <= ram[mem_addr];

  // scoreboard counters
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == HLT_OP) w[31:26] = 6'b000000;
    return w;
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
    chk({tag, "_addr"},   {22'd0, mem_addr}, 32'd0);
    chk({tag, "_instr"},  instr, 32'd0);
    chk({tag, "_ipc"},    {22'd0, instr_pc}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_fault"},  {31'd0, fault}, 32'd0);
  endtask

  // release reset and check the two-cycle warm-up ending with word 0
  task automatic release_and_start(input string tag);
    tick();
    rst = 1'b0;
    tick();
    chk({tag, "_warm_valid"}, {31'd0, instr_valid}, 32'd0);
    tick();
    chk({tag, "_first_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_first_instr"}, instr, ram[0]);
    chk({tag, "_first_pc"},    {22'd0, instr_pc}, 32'd0);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int          exp_pc;
  logic        redir_prev;
  int          guard;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = rand_word();
    ram[47]  = {HLT_OP, 26'd0};
    ram[127] = 32'hC0DE_127F & 32'h03FF_FFFF; // opcode 0, not hlt

    // ---- reset state ----
    #3;
    chk_reset_values("reset");

    // ---- 1) warm-up and back-to-back delivery ----
    instr_ready = 1'b1;
    release_and_start("s1");
    tick();
    chk("s1_b_valid", {31'd0, instr_valid}, 32'd1);
    chk("s1_b_instr", instr, ram[1]);
    chk("s1_b_pc",    {22'd0, instr_pc}, 32'd1);

    // ---- 2) stall three cycles holding B/1 ----
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s2_hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("s2_hold_instr", instr, ram[1]);
      chk("s2_hold_pc",    {22'd0, instr_pc}, 32'd1);
      chk("s2_hold_addr",  {22'd0, mem_addr}, 32'd2);
    end
    instr_ready = 1'b1;
    tick();
    chk("s2_c_instr", instr, ram[2]);
    chk("s2_c_pc",    {22'd0, instr_pc}, 32'd2);
    tick();
    chk("s2_d_instr", instr, ram[3]);
    chk("s2_d_pc",    {22'd0, instr_pc}, 32'd3);

    // ---- 3) redirect to 26 while stalled ----
    instr_ready     = 1'b0;
    redirect        = 1'b1;
    redirect_target = 10'd26;
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b1;
    chk("s3_flush_valid", {31'd0, instr_valid}, 32'd0);
    chk("s3_flush_addr",  {22'd0, mem_addr}, 32'd26);
    tick();
    chk("s3_tgt_valid", {31'd0, instr_valid}, 32'd1);
    chk("s3_tgt_instr", instr, ram[26]);
    chk("s3_tgt_pc",    {22'd0, instr_pc}, 32'd26);

    // ---- 4) run up to hlt at 47, then resume ----
    for (int k = 27; k <= 47; k++) begin
      tick();
      chk("s4_run_valid", {31'd0, instr_valid}, 32'd1);
      chk("s4_run_instr", instr, ram[k]);
      chk("s4_run_pc",    {22'd0, instr_pc}, k);
    end
    chk("s4_hlt_halted", {31'd0, halted}, 32'd1);
    chk("s4_hlt_addr",   {22'd0, mem_addr}, 32'd48);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s4_halt_valid",  {31'd0, instr_valid}, 32'd0);
      chk("s4_halt_halted", {31'd0, halted}, 32'd1);
      chk("s4_halt_addr",   {22'd0, mem_addr}, 32'd48);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("s4_res_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("s4_res_valid", {31'd0, instr_valid}, 32'd1);
    chk("s4_res_instr", instr, ram[48]);
    chk("s4_res_pc",    {22'd0, instr_pc}, 32'd48);

    // ---- 5) redirect to 127, then fault ----
    redirect        = 1'b1;
    redirect_target = 10'd127;
    tick();
    redirect = 1'b0;
    chk("s5_flush_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("s5_x_valid", {31'd0, instr_valid}, 32'd1);
    chk("s5_x_instr", instr, ram[127]);
    chk("s5_x_pc",    {22'd0, instr_pc}, 32'd127);
    chk("s5_x_fault", {31'd0, fault}, 32'd0);
    tick();
    chk("s5_fault",       {31'd0, fault}, 32'd1);
    chk("s5_fault_valid", {31'd0, instr_valid}, 32'd0);
    redirect        = 1'b1;
    redirect_target = 10'd5;
    tick();
    redirect = 1'b0;
    chk("s5_ign_fault", {31'd0, fault}, 32'd1);
    chk("s5_ign_addr",  {22'd0, mem_addr}, 32'd128);
    chk("s5_ign_valid", {31'd0, instr_valid}, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_values("s5_rst");
    release_and_start("s5_restart");

    // ---- 6) asynchronous reset mid-stream at pc 20 ----
    guard = 0;
    while (mem_addr != 10'd20 && guard < 40) begin
      tick();
      guard++;
    end
    chk("s6_reach_pc20", {22'd0, mem_addr}, 32'd20);
    chk("s6_pre_valid",  {31'd0, instr_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_values("s6_rst");
    ram[47] = rand_word(); // no halt in the random phase
    release_and_start("s6_restart");

    // ---- randomized phase against an in-order PC model ----
    // The model tracks the PC of the next word decode must receive. With the
    // PC kept inside memory and no halt word, a word must be on offer every
    // cycle except the one right after a redirect.
    exp_pc     = 0;
    redir_prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      chk("rnd_valid", {31'd0, instr_valid}, {31'd0, !redir_prev});
      if (instr_valid) begin
        chk("rnd_pc",    {22'd0, instr_pc}, exp_pc);
        chk("rnd_instr", instr, ram[exp_pc]);
      end
      if (i % 64 == 0) begin
        chk("rnd_halted", {31'd0, halted}, 32'd0);
        chk("rnd_fault",  {31'd0, fault}, 32'd0);
      end
      instr_ready     = ($urandom_range(0, 9) < 7);
      redirect        = (exp_pc >= 110) || ($urandom_range(0, 14) == 0);
      redirect_target = 10'($urandom_range(0, 100));
      resume          = ($urandom_range(0, 9) == 0);
      if (instr_valid && instr_ready) exp_pc++;
      if (redirect) exp_pc = int'(redirect_target);
      redir_prev = redirect;
      tick();
    end
    redirect = 1'b0;
    resume   = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
